// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared funct3 and FSM state encodings
// Ports: none (package).
package data_mem_responder_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_mem_lane_fmt.sv
// rtl/data_mem_responder_mem_lane_fmt.sv - byte-lane alignment, load extension, error detection
// Ports:
//   is_write  in   1 = store, 0 = load
//   funct3    in   RV32I load/store funct3
//   addr_lo   in   byte offset within the word
//   wdata     in   right-aligned store data
//   rword     in   full memory word at the addressed location
//   wmask     out  byte-lane write enables (all zero for loads and errors)
//   wdata_al  out  store data shifted into its byte lanes
//   rdata     out  extracted and extended load data (zero for stores and errors)
//   err       out  misaligned access or illegal funct3
module mem_lane_fmt
  import data_mem_responder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           is_write,
  input  logic [2:0]     funct3,
  input  logic [1:0]     addr_lo,
  input  logic [N-1:0]   wdata,
  input  logic [N-1:0]   rword,
  output logic [N/8-1:0] wmask,
  output logic [N-1:0]   wdata_al,
  output logic [N-1:0]   rdata,
  output logic           err
);

  logic           illegal_f3;
  logic           misalign;
  logic [4:0]     shamt;
  logic [N/8-1:0] base_mask;
  logic [N-1:0]   shifted;

  always_comb begin
    if (is_write) begin
      illegal_f3 = (funct3 > F3_SW);
    end else begin
      illegal_f3 = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                     funct3 == F3_LBU || funct3 == F3_LHU);
    end

    // funct3[1:0] encodes the access size for every legal load/store
    misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    err = illegal_f3 || misalign;

    shamt = {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00:   base_mask = {{(N/8-1){1'b0}}, 1'b1};
      2'b01:   base_mask = {{(N/8-2){1'b0}}, 2'b11};
      default: base_mask = '1;
    endcase

    wmask    = (is_write && !err) ? (base_mask << addr_lo) : '0;
    wdata_al = wdata << shamt;

    shifted = rword >> shamt;
    case (funct3)
      F3_LB:   rdata = {{(N-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata = {{(N-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   rdata = shifted;
      F3_LBU:  rdata = {{(N-8){1'b0}}, shifted[7:0]};
      F3_LHU:  rdata = {{(N-16){1'b0}}, shifted[15:0]};
      default: rdata = '0;
    endcase
    if (is_write || err) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store memory responder with wait states
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE and out of reset)
//   req_write, req_addr    store/load select, byte address
//   req_funct3, req_wdata  RV32I size/sign code, right-aligned store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     extended load data, error flag
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int N           = 32,
  parameter int MEM_ADDR    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [MEM_ADDR-1:0] req_addr,
  input  logic [2:0]          req_funct3,
  input  logic [N-1:0]        req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_rdata,
  output logic                rsp_err
);

  localparam int         DEPTH     = 2 ** (MEM_ADDR - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [N-1:0] mem_q [DEPTH];

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [MEM_ADDR-1:0] addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [N-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                enter_resp;
  logic                cur_write;
  logic [MEM_ADDR-1:0] cur_addr;
  logic [2:0]          cur_f3;
  logic [N-1:0]        cur_wdata;
  logic [N/8-1:0]      lane_wmask;
  logic [N-1:0]        lane_wdata;
  logic [N-1:0]        lane_rdata;
  logic                lane_err;

  assign req_ready = rst && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With zero wait states the access completes on the accept edge itself,
  // so the lane formatter must see the live request rather than the latch.
  assign cur_write = (state_q == ST_IDLE) ? req_write  : wr_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
  assign cur_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

  mem_lane_fmt #(.N(N)) u_lane_fmt (
    .is_write (cur_write),
    .funct3   (cur_f3),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (mem_q[cur_addr[MEM_ADDR-1:2]]),
    .wmask    (lane_wmask),
    .wdata_al (lane_wdata),
    .rdata    (lane_rdata),
    .err      (lane_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // counter holds the remaining wait cycles including the current one
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = lane_rdata;
      rsp_err_d   = lane_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= 3'b000;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Stores commit on the edge entering RESP; wmask is zero for loads/errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (enter_resp) begin
      for (int b = 0; b < N / 8; b++) begin
        if (lane_wmask[b]) begin
          mem_q[cur_addr[MEM_ADDR-1:2]][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic        rsp_ready  [2];
  logic [7:0]  req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic        rsp_err    [2];
  logic [31:0] rsp_rdata  [2];

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  ref_mem [2][256];
  int          wait_of [2] = '{2, 0};

  data_mem_responder #(.N(32), .MEM_ADDR(8), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.N(32), .MEM_ADDR(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) ref_mem[i][k] = 8'h00;
  endtask

  // Byte-array memory model driven by the load/store rules.
  task automatic model_access(input int i, input bit w, input logic [7:0] a,
                              input logic [2:0] f3, input logic [31:0] wd,
                              output logic [31:0] rd, output bit e);
    int nbytes;
    bit legal;
    nbytes = 1 << f3[1:0];
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e  = !legal || ((int'(a) % nbytes) != 0);
    rd = 32'h0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < nbytes; k++) ref_mem[i][(int'(a) + k) % 256] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nbytes; k++) rd[8*k +: 8] = ref_mem[i][(int'(a) + k) % 256];
        if (f3 == 3'd0 && rd[7])  rd[31:8]  = 24'hFFFFFF;
        if (f3 == 3'd1 && rd[15]) rd[31:16] = 16'hFFFF;
      end
    end
  endtask

  // One request/response exchange; starts and ends just after a negedge.
  task automatic txn(input int i, input bit w, input logic [7:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output bit e, output int lat);
    logic [31:0] held;
    logic        held_e;
    int          guard;
    total++;
    if (req_ready[i] !== 1'b1) begin
      bad++;
      $display("FAIL txn_req_ready inst=%0d actual=%b required=1", i, req_ready[i]);
    end
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a;
    req_funct3[i] = f3; req_wdata[i] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_write[i] = 1'($urandom); req_addr[i] = 8'($urandom);
    req_funct3[i] = 3'($urandom); req_wdata[i] = $urandom;
    lat = 1; guard = 0;
    while (rsp_valid[i] !== 1'b1 && guard < 40) begin
      total++;
      if (req_ready[i] !== 1'b0) begin
        bad++;
        $display("FAIL wait_req_ready inst=%0d actual=%b required=0", i, req_ready[i]);
      end
      @(negedge clk);
      lat++; guard++;
    end
    if (guard >= 40) begin
      total++; bad++;
      $display("FAIL rsp_timeout inst=%0d actual=no_rsp required=rsp_valid", i);
      rd = 'x; e = 1'b1;
      return;
    end
    held = rsp_rdata[i]; held_e = rsp_err[i];
    repeat (hold) begin
      @(negedge clk);
      total++;
      if (rsp_valid[i] !== 1'b1 || rsp_rdata[i] !== held || rsp_err[i] !== held_e ||
          req_ready[i] !== 1'b0) begin
        bad++;
        $display("FAIL stall_stable inst=%0d actual=v%b d%h e%b r%b required=v1 d%h e%b r0",
                 i, rsp_valid[i], rsp_rdata[i], rsp_err[i], req_ready[i], held, held_e);
      end
    end
    rd = held; e = held_e;
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    total++;
    if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
      bad++;
      $display("FAIL txn_idle inst=%0d actual=v%b r%b required=v0 r1", i, rsp_valid[i], req_ready[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_write[i] = 0; rsp_ready[i] = 0;
      req_addr[i] = 0; req_funct3[i] = 0; req_wdata[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'h0 ||
          rsp_err[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d actual=r%b v%b d%h e%b required=r0 v0 d0 e0",
                 i, req_ready[i], rsp_valid[i], rsp_rdata[i], rsp_err[i]);
      end
    end
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (req_ready[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_ready inst=%0d actual=%b required=1", i, req_ready[i]);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, exp;
    bit e, ee;
    int lat;
    txn(0, 1, 8'h10, 3'b010, 32'hDEADBEEF, 0, rd, e, lat);
    model_access(0, 1, 8'h10, 3'b010, 32'hDEADBEEF, exp, ee);
    total++;
    if (e !== 1'b0 || lat != 3) begin
      bad++; $display("FAIL sw_word actual=e%b lat%0d required=e0 lat3", e, lat);
    end
    txn(0, 0, 8'h10, 3'b010, 32'h0, 0, rd, e, lat);
    model_access(0, 0, 8'h10, 3'b010, 32'h0, exp, ee);
    total++;
    if (rd !== 32'hDEADBEEF || rd !== exp || e !== 1'b0 || lat != 3) begin
      bad++; $display("FAIL lw_word actual=%h e%b lat%0d required=deadbeef e0 lat3", rd, e, lat);
    end
  endtask

  task automatic test_byte();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b010};
    logic [7:0]  as   [3] = '{8'h11, 8'h11, 8'h10};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF};
    logic [31:0] rd, mexp;
    bit e, ee;
    int lat;
    txn(0, 1, 8'h11, 3'b000, 32'h00000080, 0, rd, e, lat);
    model_access(0, 1, 8'h11, 3'b000, 32'h00000080, mexp, ee);
    for (int k = 0; k < 3; k++) begin
      txn(0, 0, as[k], f3s[k], 32'h0, 0, rd, e, lat);
      model_access(0, 0, as[k], f3s[k], 32'h0, mexp, ee);
      total++;
      if (rd !== exps[k] || rd !== mexp || e !== 1'b0) begin
        bad++; $display("FAIL byte_load_%0d actual=%h e%b required=%h e0", k, rd, e, exps[k]);
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] rd, mexp;
    bit e, ee;
    int lat;
    txn(0, 0, 8'h13, 3'b001, 32'h0, 0, rd, e, lat);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lh_misalign actual=%h e%b required=0 e1", rd, e);
    end
    txn(0, 1, 8'h12, 3'b010, 32'h1, 0, rd, e, lat);
    model_access(0, 1, 8'h12, 3'b010, 32'h1, mexp, ee);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL sw_misalign actual=e%b required=e1", e);
    end
    txn(0, 0, 8'h10, 3'b010, 32'h0, 0, rd, e, lat);
    total++;
    if (rd !== 32'hDEAD80EF || e !== 1'b0) begin
      bad++; $display("FAIL err_no_write actual=%h e%b required=dead80ef e0", rd, e);
    end
    txn(1, 1, 8'h40, 3'b011, 32'hFFFF_FFFF, 0, rd, e, lat);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL store_illegal_f3 actual=e%b required=e1", e);
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    bit e;
    int lat;
    txn(0, 0, 8'h10, 3'b010, 32'h0, 5, rd, e, lat);
    total++;
    if (rd !== 32'hDEAD80EF || e !== 1'b0) begin
      bad++; $display("FAIL stall_data actual=%h e%b required=dead80ef e0", rd, e);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    bit e;
    int lat;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h20;
    req_funct3[0] = 3'b010; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL wait_reset actual=v%b r%b required=v0 r0", rsp_valid[0], req_ready[0]);
    end
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    txn(0, 0, 8'h20, 3'b010, 32'h0, 0, rd, e, lat);
    total++;
    if (rd !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL store_discarded actual=%h e%b required=0 e0", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, mexp, wd;
    bit e, ee;
    int lat;
    for (int k = 0; k < 4; k++) begin
      wd = (k == 0) ? 32'h12345678 : $urandom;
      txn(1, 1, 8'hFC, 3'b010, wd, 0, rd, e, lat);
      model_access(1, 1, 8'hFC, 3'b010, wd, mexp, ee);
      total++;
      if (lat != 1 || e !== 1'b0) begin
        bad++; $display("FAIL b2b_sw_%0d actual=lat%0d e%b required=lat1 e0", k, lat, e);
      end
      txn(1, 0, 8'hFC, 3'b010, 32'h0, 0, rd, e, lat);
      model_access(1, 0, 8'hFC, 3'b010, 32'h0, mexp, ee);
      total++;
      if (lat != 1 || rd !== wd || rd !== mexp || e !== 1'b0) begin
        bad++; $display("FAIL b2b_lw_%0d actual=%h lat%0d required=%h lat1", k, rd, lat, wd);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mexp, wd;
    logic [7:0]  a;
    logic [2:0]  f3;
    bit w, e, ee;
    int lat;
    for (int n = 0; n < 120; n++) begin
      for (int i = 0; i < 2; i++) begin
        w  = 1'($urandom);
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
             (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000));
        a  = 8'($urandom);
        if ($urandom_range(0, 1)) a[1:0] = 2'b00;
        wd = $urandom;
        txn(i, w, a, f3, wd, $urandom_range(0, 2), rd, e, lat);
        model_access(i, w, a, f3, wd, mexp, ee);
        total++;
        if (rd !== mexp || e !== ee || lat != wait_of[i] + 1) begin
          bad++;
          $display("FAIL random_op inst=%0d w%b a%h f3=%0d actual=%h e%b lat%0d required=%h e%b lat%0d",
                   i, w, a, f3, rd, e, lat, mexp, ee, wait_of[i] + 1);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_err();
    test_stall();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits.
REQ-002 SHALL have parameter MEM_ADDR, default 8, byte-address width (2^MEM_ADDR bytes of storage).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states between accept and response (legal range 0..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, MEM_ADDR bits: byte address.
REQ-010 SHALL have port req_funct3, input, 3 bits: RV32I load/store funct3 (size and sign).
REQ-011 SHALL have port req_wdata, input, N bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, N bits: load data, extended to N bits; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: misaligned access or illegal funct3.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, latching write, addr, funct3 and wdata.
REQ-018 SHALL transition IDLE->WAIT on accept if WAIT_CYCLES>0, else IDLE->RESP.
REQ-019 SHALL count down in WAIT and move to RESP after exactly WAIT_CYCLES cycles, so that rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-021 SHALL store little-endian; byte i of word w is at byte address 4w+i.
REQ-022 SHALL handle loads by funct3: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-023 SHALL handle stores by funct3: 000 SB, 001 SH, 010 SW, writing only the addressed byte lanes.
REQ-024 SHALL flag rsp_err=1 and perform no write for any of: a halfword access with addr[0]=1, a word access with addr[1:0]≠0, load funct3 in {011,110,111}, or store funct3 ≥ 011.
REQ-025 SHALL commit a store on the edge entering RESP; a load SHALL sample memory on that same edge.
REQ-026 SHALL never block req_ready in IDLE, and SHALL ignore req_* in WAIT/RESP (no queueing, one outstanding request).
REQ-027 SHALL wrap addresses modulo 2^MEM_ADDR; no out-of-range error.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, force state IDLE, wait counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0 and all memory bytes 0.
REQ-029 SHALL drive req_ready to 0 while rst=0, and to 1 on the first cycle after rst returns to 1.
REQ-030 SHALL discard an in-flight request if reset occurs in WAIT; an uncommitted store leaves memory at its reset value.

Structure
REQ-031 SHALL place the funct3 encodings (LB..LHU, SB..SW) and the state encoding in the shared macros/package file.
REQ-032 SHALL use one combinational sub-module, mem_lane_fmt, for byte-lane write-mask/data alignment, load extraction/extension and misalignment detection.
REQ-033 SHALL keep storage as 2^(MEM_ADDR-2) words of N bits inside data_mem_responder.

Verification
REQ-034 SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid at accept+3 with WAIT_CYCLES=2.
REQ-035 SHALL cover: SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-036 SHALL cover: LH addr 0x13 -> rsp_err=1, rsp_rdata 0; SW addr 0x12 data 1 -> rsp_err=1, and LW 0x10 is unchanged.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; IDLE after handshake.
REQ-038 SHALL cover: SW 0x20 data 0x12345678 with rst=0 asserted one cycle after accept -> LW 0x20 after reset returns 0.
REQ-039 SHALL cover: WAIT_CYCLES=0 -> back-to-back SW/LW to 0xFC with rsp_valid one cycle after each accept and correct data.
